uart_word_assembler: RTL
========================

// Module: uart_word_assembler
// PURPOSE
// - Packs the byte stream from the UART receiver into 32-bit words for debug_unit.
// - Sits between uart_rx (i_rx_done/i_rx_data) and debug_unit (i_data_ready/i_data).
// - Assembles MSB-first, so "\0chm" arrives as 00 63 68 6D and yields 0x0063686D.
// - Optionally drops a stale partial word after an inter-byte timeout, resynchronising the link.
// PARAMETERS
// - NB_DATA        32         output word width; must be a multiple of NB_BYTE
// - NB_BYTE        8          UART byte width
// - TIMEOUT_CYCLES 1_000_000  idle clocks between bytes before a partial word is dropped (RX_TIMEOUT_EN only)
// PORTS
// - i_clk          in   1        system clock; all logic on rising edge
// - i_reset        in   1        asynchronous, active-low reset
// - i_rx_done      in   1        1-cycle strobe: i_rx_data holds a valid received byte
// - i_rx_data      in   NB_BYTE  received byte
// - i_flush        in   1        synchronous: discard any partial word
// - o_data         out  NB_DATA  assembled word; held stable until the next word completes
// - o_data_ready   out  1        1-cycle pulse: o_data is new (drives debug_unit i_data_ready)
// - o_busy         out  1        1 while a partial word (1..NB_DATA/NB_BYTE-1 bytes) is pending
// - o_timeout      out  1        1-cycle pulse: a partial word was dropped by timeout
// BEHAVIOUR
// - Reset (i_reset=0, async): state=IDLE, byte count=0, shift reg=0, timer=0.
//   o_data=0, o_data_ready=0, o_busy=0, o_timeout=0.
// - Reset mid-word: the partial word is lost and the next byte is byte 0.
// - Let NB = NB_DATA/NB_BYTE. Each accepted byte does shift <= {shift[NB_DATA-NB_BYTE-1:0], i_rx_data}, cnt++.
// - FSM states:
//   - IDLE:    cnt=0. On i_rx_done: accept byte, go to COLLECT.
//   - COLLECT: on i_rx_done: accept byte.
//       If it is byte NB: o_data <= full word, cnt <= 0, go to DONE.
//       Otherwise stay in COLLECT.
//   - DONE:    o_data_ready=1 for exactly this cycle.
//       If i_rx_done this cycle: accept as byte 0 of the next word, go to COLLECT; no byte is lost.
//       Otherwise go to IDLE.
// - Latency: the NB-th i_rx_done at edge N gives o_data_ready=1 and a valid o_data in cycle N+1.
// - o_data is updated only on completion. Partial bytes never appear on o_data.
// - o_busy = (state==COLLECT), registered.
// - i_flush=1 in any state: cnt<=0, timer<=0, go to IDLE.
//   - If i_rx_done arrives in the same cycle, flush wins and the byte is dropped.
//   - A DONE pulse already in flight still occurs.
//   - o_data keeps its last completed word.
// - There is no backpressure; debug_unit must sample on the o_data_ready cycle.
// - All-ones word 0xFFFFFFFF (end-of-program marker) is passed through like any other word.
// CONFIGURATION
// - Macro: RX_TIMEOUT_EN.
// - Defined:
//   - In COLLECT the timer counts every cycle without i_rx_done and clears on each accepted byte.
//   - When timer == TIMEOUT_CYCLES-1: clear cnt and shift, go to IDLE, o_timeout=1 for 1 cycle.
//   - If i_rx_done coincides with expiry, the byte is accepted and the timer cleared; no timeout.
//   - Timer width = $clog2(TIMEOUT_CYCLES).
// - Undefined: no timer logic, o_timeout tied 0, and a partial word waits indefinitely.
// TESTING (bench uses TIMEOUT_CYCLES=16)
// - Reset: assert i_reset=0 mid-stream.
//   -> All outputs are 0.
//   -> After release, 11 22 33 44 -> o_data=0x11223344.
// - Basic word: bytes 00 63 68 6D at random gaps.
//   -> o_data_ready is high exactly 1 cycle, the cycle after the 4th strobe.
//   -> o_data=0x0063686D.
//   -> o_busy=1 from after byte 1 until byte 4.
// - Back-to-back words: AA BB CC DD, then FF FF FF FF, with the 5th strobe in the DONE cycle.
//   -> Two pulses: 0xAABBCCDD, then 0xFFFFFFFF.
// - Timeout (RX_TIMEOUT_EN): AA BB, then 16 idle cycles.
//   -> o_timeout pulses once, o_busy=0, no o_data_ready.
//   -> Then 01 02 03 04 -> 0x01020304.
// - Timeout boundary (RX_TIMEOUT_EN): byte arrives exactly on the expiry cycle.
//   -> No o_timeout, and the word completes normally.
// - Flush: 12 34, then i_flush together with a 56 strobe, then 9A BC DE F0.
//   -> o_data=0x9ABCDEF0.
//   -> o_data holds its prior value until then.

Source files
------------

// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bundle between uart_rx, uart_word_assembler and debug_unit.
//   i_rx_done/i_rx_data : received-byte strobe and byte
//   i_flush             : discard any partial word
//   o_data/o_data_ready : assembled word and its 1-cycle "new" pulse
//   o_busy/o_timeout    : partial word pending / partial word dropped on timeout
// Modports: slave = assembler side, master = producer/consumer (or bench) side.
interface uart_word_assembler_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
);
  logic               i_rx_done;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_flush;
  logic [NB_DATA-1:0] o_data;
  logic               o_data_ready;
  logic               o_busy;
  logic               o_timeout;

  modport slave (
    input  i_rx_done, i_rx_data, i_flush,
    output o_data, o_data_ready, o_busy, o_timeout
  );

  modport master (
    output i_rx_done, i_rx_data, i_flush,
    input  o_data, o_data_ready, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_word_assembler.sv
// Packs the uart_rx byte stream MSB-first into NB_DATA-bit words for debug_unit.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : uart_word_assembler_if.slave (byte strobe in, word/pulse/status out)
// Optional feature macro RX_TIMEOUT_EN: drop a partial word after TIMEOUT_CYCLES
// idle clocks in COLLECT and pulse o_timeout. Undefined: no timer, o_timeout=0.
module uart_word_assembler #(
  parameter int NB_DATA        = 32,
  parameter int NB_BYTE        = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                    i_clk,
  input logic                    i_reset,
  uart_word_assembler_if.slave   bus
);
  localparam int NB    = NB_DATA / NB_BYTE;
  localparam int CNT_W = $clog2(NB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  if ((NB_DATA % NB_BYTE) != 0 || NB_DATA < 2 * NB_BYTE || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_word_assembler: illegal NB_DATA/NB_BYTE/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [NB_DATA-1:0] shift;
  logic [NB_DATA-1:0] word;
  logic               accept;
  logic               last_byte;
  logic               expire;

  // Flush beats a coincident strobe: that byte is dropped.
  assign accept    = bus.i_rx_done && !bus.i_flush;
  assign last_byte = accept && (cnt == LAST);

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;
  logic          timeout_q;

  // A strobe on the expiry cycle rescues the word; flush also suppresses it.
  assign expire = (state == COLLECT) && !bus.i_rx_done && !bus.i_flush &&
                  (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state != COLLECT || bus.i_rx_done || bus.i_flush || expire)
        timer <= '0;
      else
        timer <= timer + 1'b1;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign expire        = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state. Every state accepts a byte the same way, so DONE can
  // take byte 0 of the next word without losing it.
  always_comb begin
    state_nxt = state;
    if (bus.i_flush || expire)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = last_byte ? DONE : COLLECT;
    else if (state == DONE)
      state_nxt = IDLE;
  end

  // FSM: outputs, decoded from the state register
  always_comb begin
    bus.o_data_ready = (state == DONE);
    bus.o_busy       = (state == COLLECT);
  end

  // Datapath: shift register, byte count, output word
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt   <= '0;
      shift <= '0;
      word  <= '0;
    end else if (bus.i_flush) begin
      cnt <= '0;
    end else if (expire) begin
      cnt   <= '0;
      shift <= '0;
    end else if (accept) begin
      shift <= {shift[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};
      cnt   <= last_byte ? '0 : cnt + 1'b1;
      // o_data only ever sees complete words
      if (last_byte) word <= {shift[NB_DATA-NB_BYTE-1:0], bus.i_rx_data};
    end
  end

  assign bus.o_data = word;
endmodule
